calc_cu: RTL and testbench
==========================

# calc_cu

Control unit for the 3-bit small-calculator datapath (`DP`). It takes a single-cycle `start` request with an operation code and drives the datapath control word cycle by cycle: clear R0, load operand A, load operand B, execute, present the result. It also supports an accumulate mode that reuses the previous result. It sits beside `DP` in the calculator top level, and its outputs connect one-to-one to the `DP` control inputs.

## Interface

No parameters. Widths are fixed by `DP`.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request pulse, sampled only in IDLE.
- `op` in 2: ALU operation, latched on accepted `start`.
- `acc` in 1: accumulate mode, latched on accepted `start`.
- `s1` out 2: MUX1 select (00 `in1`, 01 `in2`, 10 zero, 11 `aluout`).
- `wa` out 2: register-file write address.
- `we` out 1: register-file write enable.
- `raa`, `rab` out 2 each: read addresses for ports A and B.
- `rea`, `reb` out 1 each: read enables.
- `c` out 2: ALU operation.
- `s2` out 1: MUX2 select (1 passes `aluout`, 0 forces `out` to 0).
- `busy` out 1: high in every state other than IDLE.
- `done` out 1: high only in OUT; `DP` `out` is valid in that cycle.

## Operation

- States: IDLE, CLR, LDA, LDB, EXE, OUT. All outputs are registered Moore decodes of the current state.
- IDLE: all control outputs 0, `s2`=0.
  - If `start`=1, latch `op` into `op_q` and latch `acc_eff` = `acc` AND `hist`.
  - Next state is LDB if `acc_eff`=1, otherwise CLR.
- CLR: `s1`=10, `wa`=00, `we`=1 (R0 ← 0). Next state is LDA.
- LDA: `s1`=00, `wa`=01, `we`=1 (R1 ← `in1`). Next state is LDB.
- LDB: `s1`=01, `wa`=10, `we`=1 (R2 ← `in2`). Next state is EXE.
- EXE: `rea`=`reb`=1, `rab`=10, `c`=`op_q`, `s1`=11, `wa`=11, `we`=1 (R3 ← A op R2).
  - `raa`=01 normally; `raa`=11 (R3) when `acc_eff`=1.
  - Next state is OUT.
- OUT: `rea`=`reb`=1, `raa`=11, `rab`=00, `c`=00 (ADD), `s2`=1, `done`=1, `busy`=1. This gives `out` = R3 + R0 = R3.
  - Set `hist`=1. Next state is IDLE.
- `hist` is 1 once any non-accumulate sequence has completed since reset. Until then `acc` is ignored and treated as 0, so R0 and R3 are defined before they are reused.
- `start` is ignored while `busy`=1. No queuing.
- The requester holds `in1` stable through LDA and `in2` stable through LDB. `calc_cu` does not capture data.
- Arithmetic is the ALU's 3-bit result and wraps modulo 8. `calc_cu` performs no arithmetic.

## Timing

- `start` accepted on edge t:
  - Normal mode: CLR in cycle t+1, `done` in cycle t+5.
  - Accumulate mode: LDB in cycle t+1, `done` in cycle t+3.
- Exactly one `done` cycle per accepted request. `busy` falls in the cycle after OUT.
- Back-to-back: a `start` held high in the IDLE cycle after OUT is accepted. Minimum spacing is 6 cycles (normal) or 4 (accumulate).
- Reset values, all asynchronous:
  - state = IDLE.
  - `s1`, `wa`, `raa`, `rab`, `c` = 00.
  - `we`, `rea`, `reb`, `s2`, `busy`, `done` = 0.
  - `hist`, `op_q`, `acc_eff` = 0.
- Reset mid-sequence: `we` drops immediately without waiting for a clock edge. The sequence is abandoned with no `done`, and `hist` is cleared.

## Structure

- Shared package `calc_pkg` holds:
  - State enum.
  - Register addresses R0=00, R1=01, R2=10, R3=11.
  - MUX1 selects SEL_IN1, SEL_IN2, SEL_ZERO, SEL_ALU.
  - ALU_ADD=00.
- Single module, no sub-modules: one state register with next-state logic plus one registered output decode.

## Test plan

- Reset, then idle 3 cycles: all outputs 0, `busy`=0, `done`=0.
- Integrated with `DP`: `in1`=3, `in2`=2, `op`=00, `start` pulse. Expect `done` 5 cycles later with `out`=5, and the control-word sequence CLR/LDA/LDB/EXE/OUT exact.
- After the previous case: `acc`=1, `in2`=1, `op`=00. Expect `done` 3 cycles later with `out`=6 and `raa`=11 in EXE. A wrap case, R3=7 plus `in2`=1, gives `out`=0.
- `acc`=1 as the first request after reset: full 5-cycle sequence runs (CLR present) with `raa`=01 in EXE.
- `start` re-pulsed during LDA and EXE: ignored, exactly one `done`, `op_q` unchanged; `op`=10 check gives `c`=10 in EXE and `c`=00 in OUT.
- Assert `rst` during LDB: `we`=0 and state IDLE with no clock edge, no `done`; next `acc`=1 request runs as normal (`hist` cleared).

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the small-calculator control unit and its
// datapath. It holds the control FSM state encoding, the register-file
// addresses, the MUX1 select codes and the ALU ADD opcode.
package calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LDA  = 3'd2,
    S_LDB  = 3'd3,
    S_EXE  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  // Register-file addresses
  localparam logic [1:0] R0 = 2'b00;
  localparam logic [1:0] R1 = 2'b01;
  localparam logic [1:0] R2 = 2'b10;
  localparam logic [1:0] R3 = 2'b11;

  // MUX1 selects (register-file write data)
  localparam logic [1:0] SEL_IN1  = 2'b00;
  localparam logic [1:0] SEL_IN2  = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam logic [1:0] SEL_ALU  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;

endpackage

// File: rtl/calc_cu_if.sv
// calc_cu_if: request and control-word bundle around calc_cu.
//   master : the requester side. It drives start/op/acc and observes the control word.
//   slave  : calc_cu. It receives the request and drives the control word,
//            busy/done and the current FSM state for observation.
// Handshake: start is a single-cycle request. It is accepted on a rising edge
// only while busy=0. When busy=1 it is ignored and is not queued. done marks
// the single cycle in which the datapath output is valid.
interface calc_cu_if;
  import calc_pkg::*;

  logic       start;
  logic [1:0] op;
  logic       acc;

  logic [1:0] s1;
  logic [1:0] wa;
  logic       we;
  logic [1:0] raa;
  logic [1:0] rab;
  logic       rea;
  logic       reb;
  logic [1:0] c;
  logic       s2;
  logic       busy;
  logic       done;
  state_t     state;

  modport master (
    output start, op, acc,
    input  s1, wa, we, raa, rab, rea, reb, c, s2, busy, done, state
  );

  modport slave (
    input  start, op, acc,
    output s1, wa, we, raa, rab, rea, reb, c, s2, busy, done, state
  );

endinterface

// File: rtl/calc_cu.sv
// calc_cu: control unit for the 3-bit small-calculator datapath.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : calc_cu_if.slave. It carries the request in (start/op/acc) and the
//         datapath control word out (s1, wa, we, raa, rab, rea, reb, c, s2),
//         together with busy, done and the debug state.
// Sequence: IDLE -> CLR -> LDA -> LDB -> EXE -> OUT -> IDLE.
// An accumulate request goes IDLE -> LDB and reuses R3 as operand A.
module calc_cu
  import calc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  calc_cu_if.slave  bus
);

  state_t     state, state_d;
  logic [1:0] op_q, op_q_d;
  logic       acc_eff, acc_eff_d;
  logic       hist, hist_d;

  // Registered control word
  logic [1:0] s1_q, wa_q, raa_q, rab_q, c_q;
  logic       we_q, rea_q, reb_q, s2_q, busy_q, done_q;
  // Decoded control word for the next state
  logic [1:0] s1_d, wa_d, raa_d, rab_d, c_d;
  logic       we_d, rea_d, reb_d, s2_d, busy_d, done_d;

  // Next-state logic, including the request latches
  always_comb begin
    state_d   = state;
    op_q_d    = op_q;
    acc_eff_d = acc_eff;
    hist_d    = hist;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          op_q_d    = bus.op;
          // Accumulate is honoured only once R0 and R3 hold defined values.
          acc_eff_d = bus.acc & hist;
          state_d   = (bus.acc & hist) ? S_LDB : S_CLR;
        end
      end
      S_CLR: state_d = S_LDA;
      S_LDA: state_d = S_LDB;
      S_LDB: state_d = S_EXE;
      S_EXE: state_d = S_OUT;
      S_OUT: begin
        hist_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The output decode uses the next state, so the registered control word is
  // aligned with the state register. It is still a Moore function of state.
  always_comb begin
    s1_d   = 2'b00;
    wa_d   = 2'b00;
    we_d   = 1'b0;
    raa_d  = 2'b00;
    rab_d  = 2'b00;
    rea_d  = 1'b0;
    reb_d  = 1'b0;
    c_d    = ALU_ADD;
    s2_d   = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    unique case (state_d)
      S_IDLE: ;
      S_CLR: begin
        s1_d = SEL_ZERO;
        wa_d = R0;
        we_d = 1'b1;
      end
      S_LDA: begin
        s1_d = SEL_IN1;
        wa_d = R1;
        we_d = 1'b1;
      end
      S_LDB: begin
        s1_d = SEL_IN2;
        wa_d = R2;
        we_d = 1'b1;
      end
      S_EXE: begin
        rea_d = 1'b1;
        reb_d = 1'b1;
        raa_d = acc_eff_d ? R3 : R1;
        rab_d = R2;
        c_d   = op_q_d;
        s1_d  = SEL_ALU;
        wa_d  = R3;
        we_d  = 1'b1;
      end
      S_OUT: begin
        // R3 + R0 (R0 = 0) gives the result without a bypass path.
        rea_d  = 1'b1;
        reb_d  = 1'b1;
        raa_d  = R3;
        rab_d  = R0;
        c_d    = ALU_ADD;
        s2_d   = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= 2'b00;
      acc_eff <= 1'b0;
      hist    <= 1'b0;
      s1_q    <= 2'b00;
      wa_q    <= 2'b00;
      we_q    <= 1'b0;
      raa_q   <= 2'b00;
      rab_q   <= 2'b00;
      rea_q   <= 1'b0;
      reb_q   <= 1'b0;
      c_q     <= 2'b00;
      s2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      op_q    <= op_q_d;
      acc_eff <= acc_eff_d;
      hist    <= hist_d;
      s1_q    <= s1_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      raa_q   <= raa_d;
      rab_q   <= rab_d;
      rea_q   <= rea_d;
      reb_q   <= reb_d;
      c_q     <= c_d;
      s2_q    <= s2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.s1    = s1_q;
  assign bus.wa    = wa_q;
  assign bus.we    = we_q;
  assign bus.raa   = raa_q;
  assign bus.rab   = rab_q;
  assign bus.rea   = rea_q;
  assign bus.reb   = reb_q;
  assign bus.c     = c_q;
  assign bus.s2    = s2_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state;

endmodule

// File: tb/tb_calc_cu.sv
// tb_calc_cu: directed bench for calc_cu, with a behavioural stand-in for DP.
// The stand-in has a 4x3-bit register file, MUX1, the ALU (00 add, 01 sub,
// 10 and, 11 or) and MUX2.
module tb_calc_cu;
  import calc_pkg::*;

  logic clk;
  logic rst;
  logic [2:0] in1, in2;

  calc_cu_if bus ();

  calc_cu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DP stand-in ----------------
  logic [2:0] rf [4];
  logic [2:0] mux1, a_rd, b_rd, aluout, dp_out;

  always_comb begin
    a_rd = bus.rea ? rf[bus.raa] : 3'd0;
    b_rd = bus.reb ? rf[bus.rab] : 3'd0;
    case (bus.c)
      2'b00:   aluout = a_rd + b_rd;
      2'b01:   aluout = a_rd - b_rd;
      2'b10:   aluout = a_rd & b_rd;
      default: aluout = a_rd | b_rd;
    endcase
    case (bus.s1)
      SEL_IN1:  mux1 = in1;
      SEL_IN2:  mux1 = in2;
      SEL_ZERO: mux1 = 3'd0;
      default:  mux1 = aluout;
    endcase
    dp_out = bus.s2 ? aluout : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (bus.we) rf[bus.wa] <= mux1;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cw_now();
    return {bus.s1, bus.wa, bus.we, bus.raa, bus.rab, bus.rea, bus.reb,
            bus.c, bus.s2, bus.busy, bus.done};
  endfunction

  // Expected control word from the state table:
  // {s1, wa, we, raa, rab, rea, reb, c, s2, busy, done}
  function automatic logic [15:0] exp_cw(input state_t st, input logic ae, input logic [1:0] o);
    case (st)
      S_CLR:   return {2'b10, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      S_LDA:   return {2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      S_LDB:   return {2'b01, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      S_EXE:   return {2'b11, 2'b11, 1'b1, (ae ? 2'b11 : 2'b01), 2'b10, 1'b1, 1'b1, o, 1'b0, 1'b1, 1'b0};
      S_OUT:   return {2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1};
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issue one request and check every cycle until the IDLE cycle after OUT.
  // exp_acc selects the short sequence. With repulse set, start is raised
  // again (with a different op/acc) during LDA and EXE.
  task automatic do_req(input string name, input logic [1:0] o, input logic a,
                        input logic [2:0] i1, input logic [2:0] i2,
                        input logic exp_acc, input logic [2:0] exp_out,
                        input logic repulse);
    state_t seq[$];
    int dcnt;
    @(negedge clk);
    in1 = i1; in2 = i2; bus.op = o; bus.acc = a; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (exp_acc) seq = '{S_LDB, S_EXE, S_OUT};
    else         seq = '{S_CLR, S_LDA, S_LDB, S_EXE, S_OUT};
    foreach (seq[k]) exp_q.push_back(exp_cw(seq[k], exp_acc, o));
    dcnt = 0;
    foreach (seq[k]) begin
      chk($sformatf("%s_state%0d", name, k), 32'(bus.state), 32'(seq[k]));
      chk($sformatf("%s_cw%0d", name, k), 32'(cw_now()), 32'(exp_q.pop_front()));
      if (bus.done) begin
        dcnt++;
        chk($sformatf("%s_out", name), 32'(dp_out), 32'(exp_out));
      end
      if (repulse && (seq[k] == S_LDA || seq[k] == S_EXE)) begin
        bus.start = 1'b1; bus.op = ~o; bus.acc = ~a;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk($sformatf("%s_done_cnt", name), 32'(dcnt), 32'd1);
    chk($sformatf("%s_idle_cw", name), 32'(cw_now()), 32'h0);
    chk($sformatf("%s_idle_state", name), 32'(bus.state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.acc = 1'b0;
    in1 = 3'd0; in2 = 3'd0;
    #1;
    chk("rst_cw", 32'(cw_now()), 32'h0);
    chk("rst_state", 32'(bus.state), 32'(S_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_cw", i), 32'(cw_now()), 32'h0);
      chk($sformatf("idle%0d_busy", i), 32'(bus.busy), 32'd0);
    end

    // acc=1 is treated as 0 on the first request after reset: 3+2=5
    do_req("first", 2'b00, 1'b1, 3'd3, 3'd2, 1'b0, 3'd5, 1'b0);
    // Accumulate: 5+1=6, 6+1=7, then 7+1 wraps to 0
    do_req("acc1", 2'b00, 1'b1, 3'd0, 3'd1, 1'b1, 3'd6, 1'b0);
    do_req("acc2", 2'b00, 1'b1, 3'd0, 3'd1, 1'b1, 3'd7, 1'b0);
    do_req("wrap", 2'b00, 1'b1, 3'd0, 3'd1, 1'b1, 3'd0, 1'b0);
    // Normal request with start re-pulsed mid-sequence, op=10: 6 & 3 = 2
    do_req("repulse", 2'b10, 1'b0, 3'd6, 3'd3, 1'b0, 3'd2, 1'b1);
    // Normal add after accumulate: 4+1=5
    do_req("normal", 2'b00, 1'b0, 3'd4, 3'd1, 1'b0, 3'd5, 1'b0);

    // Reset during LDB: we drops and state returns to IDLE without a clock edge
    @(negedge clk);
    in1 = 3'd1; in2 = 3'd1; bus.op = 2'b00; bus.acc = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_state", 32'(bus.state), 32'(S_LDB));
    chk("pre_rst_we", 32'(bus.we), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_we", 32'(bus.we), 32'd0);
    chk("async_rst_state", 32'(bus.state), 32'(S_IDLE));
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_done", i), 32'(bus.done), 32'd0);
    end
    // hist is cleared, so acc=1 runs the full sequence: 2+4=6
    do_req("acc_after_rst", 2'b00, 1'b1, 3'd2, 3'd4, 1'b0, 3'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
